skid_pipe_reg: RTL and testbench

- Elastic pipeline register: the stage directly downstream of the pipeline's 2-to-1 operand/next-PC multiplexers, registering the selected word before the next stage.
- Valid/ready handshake on both sides, with a one-entry skid buffer so o_ready is a pure state decode, with no combinational path from i_ready.
- Synchronous flush discards in-flight words on branch redirect or hazard.

---
 rtl/pipe_pkg.sv | 14 +
 rtl/reg_en_n.sv | 27 ++
 rtl/skid_pipe_reg.sv | 114 +++++++++++
 tb/tb_skid_pipe_reg.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: state encodings,
// default data width and the stall-counter width.
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'b00;
  localparam pipe_state_t ST_BUSY  = 2'b01;
  localparam pipe_state_t ST_FULL  = 2'b10;

  localparam int PIPE_W      = 32;
  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/reg_en_n.sv
// N-bit register with load enable and synchronous active-low clear.
module reg_en_n #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (i_en) q_d = i_d;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) q_q <= '0;
    else          q_q <= q_d;
  end

  assign o_q = q_q;

endmodule

// File: rtl/skid_pipe_reg.sv
// Elastic pipeline register with a one-entry skid buffer; o_ready is decoded
// from state only. Optional stall counter enabled by defining SKID_STATS_EN.
module skid_pipe_reg
  import pipe_pkg::*;
#(
  parameter int N = PIPE_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_data,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_flush,
  output logic [N-1:0] o_data,
  output logic         o_valid,
  input  logic         i_ready
`ifdef SKID_STATS_EN
  ,
  output logic [STALL_CNT_W-1:0] o_stall_cycles
`endif
);

  pipe_state_t  state_q;
  pipe_state_t  state_d;
  logic         main_en;
  logic [N-1:0] main_d;
  logic         skid_en;
  logic [N-1:0] skid_q;
  logic         accept;
  logic         consume;

  assign o_valid = (state_q == ST_BUSY) || (state_q == ST_FULL);
  assign o_ready = (state_q != ST_FULL);
  assign accept  = i_valid & o_ready;
  assign consume = o_valid & i_ready;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    main_d  = i_data;
    skid_en = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_BUSY: begin
          if (accept && consume) begin
            main_en = 1'b1;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_en = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Nothing can be accepted here; draining promotes the skid word.
          if (consume) begin
            state_d = ST_BUSY;
            main_en = 1'b1;
            main_d  = skid_q;
          end
        end
        default: begin
          // EMPTY, and the unused encoding 11 behaves the same way.
          state_d = accept ? ST_BUSY : ST_EMPTY;
          main_en = accept;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_EMPTY;
    else          state_q <= state_d;
  end

  reg_en_n #(.N(N)) u_main (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (main_en),
    .i_d     (main_d),
    .o_q     (o_data)
  );

  reg_en_n #(.N(N)) u_skid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (skid_en),
    .i_d     (i_data),
    .o_q     (skid_q)
  );

`ifdef SKID_STATS_EN
  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] stall_d;

  // Saturating count of cycles the downstream stage holds us off; flush
  // deliberately leaves it alone.
  always_comb begin
    stall_d = stall_q;
    if (o_valid && !i_ready && (stall_q != '1))
      stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign o_stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_skid_pipe_reg.sv
// Directed self-checking bench for skid_pipe_reg; the stall-counter scenario
// is compiled only when SKID_STATS_EN is defined.
module tb_skid_pipe_reg;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] i_data;
  logic         i_valid;
  logic         o_ready;
  logic         i_flush;
  logic [N-1:0] o_data;
  logic         o_valid;
  logic         i_ready;
`ifdef SKID_STATS_EN
  logic [15:0]  o_stall_cycles;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  skid_pipe_reg #(.N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_flush (i_flush),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready)
`ifdef SKID_STATS_EN
    ,
    .o_stall_cycles (o_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b1; i_data = 32'hDEADBEEF; i_ready = 1'b0; i_flush = 1'b0;
    for (int c = 0; c < 2; c++) begin
      step();
      total_cnt++;
      if (o_valid !== 1'b0) $display("FAIL reset_valid cyc%0d got %b want 0", c, o_valid);
      else pass_cnt++;
      total_cnt++;
      if (o_data !== 32'h0) $display("FAIL reset_data cyc%0d got %h want 0", c, o_data);
      else pass_cnt++;
    end
    rst_n = 1'b1; i_valid = 1'b0;
    step();
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", o_ready);
    else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL reset_idle_valid got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_streaming();
    i_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      i_valid = 1'b1; i_data = k;
      step();
      total_cnt++;
      if (o_valid !== 1'b1 || o_data !== 32'(k))
        $display("FAIL stream_word%0d got v=%b d=%h want v=1 d=%h", k, o_valid, o_data, k);
      else pass_cnt++;
      total_cnt++;
      if (o_ready !== 1'b1) $display("FAIL stream_ready%0d got %b want 1", k, o_ready);
      else pass_cnt++;
    end
    i_valid = 1'b0;
    step();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL stream_drain got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
    step();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 32'hA || o_ready !== 1'b1)
      $display("FAIL bp_first got v=%b d=%h r=%b want v=1 d=a r=1", o_valid, o_data, o_ready);
    else pass_cnt++;
    i_data = 32'hB;
    step();
    total_cnt++;
    if (o_data !== 32'hA || o_ready !== 1'b0)
      $display("FAIL bp_full got d=%h r=%b want d=a r=0", o_data, o_ready);
    else pass_cnt++;
    i_valid = 1'b0;
    step();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 32'hA || o_ready !== 1'b0)
      $display("FAIL bp_hold got v=%b d=%h r=%b want v=1 d=a r=0", o_valid, o_data, o_ready);
    else pass_cnt++;
    i_ready = 1'b1;
    step();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 32'hB || o_ready !== 1'b1)
      $display("FAIL bp_second got v=%b d=%h r=%b want v=1 d=b r=1", o_valid, o_data, o_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // A word offered while FULL must wait and follow the skid word in order.
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h5;
    step();
    i_data = 32'h6;
    step();
    i_ready = 1'b1; i_data = 32'h7;
    step();
    total_cnt++;
    if (o_data !== 32'h6 || o_ready !== 1'b1)
      $display("FAIL b2b_skid got d=%h r=%b want d=6 r=1", o_data, o_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (o_valid !== 1'b1 || o_data !== 32'h7)
      $display("FAIL b2b_next got v=%b d=%h want v=1 d=7", o_valid, o_data);
    else pass_cnt++;
    i_valid = 1'b0;
    step();
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL b2b_empty got %b want 0", o_valid);
    else pass_cnt++;
  endtask

  task automatic test_flush_full();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'hA;
    step();
    i_data = 32'hB;
    step();
    i_flush = 1'b1; i_data = 32'hC;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1)
      $display("FAIL flush_state got v=%b r=%b want v=0 r=1", o_valid, o_ready);
    else pass_cnt++;
    i_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      total_cnt++;
      if (o_valid !== 1'b0) $display("FAIL flush_ghost cyc%0d got v=%b d=%h want v=0", c, o_valid, o_data);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    i_ready = 1'b0; i_valid = 1'b1; i_data = 32'h11;
    step();
    i_data = 32'h22;
    step();
    rst_n = 1'b0; i_valid = 1'b0;
    step();
    total_cnt++;
    if (o_valid !== 1'b0 || o_data !== 32'h0 || o_ready !== 1'b1)
      $display("FAIL midrst got v=%b d=%h r=%b want v=0 d=0 r=1", o_valid, o_data, o_ready);
    else pass_cnt++;
    rst_n = 1'b1; i_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step();
      total_cnt++;
      if (o_valid !== 1'b0) $display("FAIL midrst_ghost cyc%0d got v=%b d=%h want v=0", c, o_valid, o_data);
      else pass_cnt++;
    end
  endtask

`ifdef SKID_STATS_EN
  task automatic test_stats();
    rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    step();
    rst_n = 1'b1;
    total_cnt++;
    if (o_stall_cycles !== 16'd0) $display("FAIL stats_reset got %0d want 0", o_stall_cycles);
    else pass_cnt++;
    i_valid = 1'b1; i_data = 32'h99;
    step();
    i_valid = 1'b0;
    repeat (5) step();
    total_cnt++;
    if (o_stall_cycles !== 16'd5) $display("FAIL stats_count got %0d want 5", o_stall_cycles);
    else pass_cnt++;
    i_flush = 1'b1; i_ready = 1'b1;
    step();
    i_flush = 1'b0;
    step();
    total_cnt++;
    if (o_stall_cycles !== 16'd5) $display("FAIL stats_flush got %0d want 5", o_stall_cycles);
    else pass_cnt++;
    i_ready = 1'b0; i_valid = 1'b1;
    step();
    i_valid = 1'b0;
    repeat (70000) step();
    total_cnt++;
    if (o_stall_cycles !== 16'hFFFF) $display("FAIL stats_sat got %h want ffff", o_stall_cycles);
    else pass_cnt++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_flush = 1'b0; i_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_flush_full();
    test_reset_mid();
`ifdef SKID_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
